instr_fetch: RTL and testbench

Instruction fetch stage sitting between the program ROM (instr_mem, combinational, 8-bit address to 6-bit instruction) and the CPU core's decode stage. It owns the fetch PC, drives the ROM address, and registers each fetched word with its PC into a 2-entry prefetch buffer. The core consumes the buffer over a valid/ready handshake. A jump redirect flushes the buffer and reloads the PC.

---
 rtl/mcpu_pkg.sv | 16 +
 rtl/fetch_fifo2.sv | 57 +++++
 rtl/instr_fetch.sv | 62 ++++++
 tb/tb_instr_fetch.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mcpu_pkg.sv
// Shared types and constants for the fetch path of the small CPU.
// The PC/instruction widths here fix the layout of fetch_entry_t.
package mcpu_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 6;

    localparam logic [ADDR_W-1:0]  RESET_PC   = 8'h00;
    localparam logic [INSTR_W-1:0] FILL_INSTR = 6'h3F;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry FIFO of fetched {instr, pc}; head visible combinationally, zero when empty.
// Push into a full FIFO is accepted only together with a pop; flush empties it in one cycle.
module fetch_fifo2
    import mcpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_wr_dat,
    output fetch_entry_t o_head_dat,
    output logic [1:0]   o_count
);

    fetch_entry_t r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;

    logic         w_push;
    logic         w_pop;

    assign w_pop  = i_pop & (r_count != 2'd0);
    assign w_push = i_push & ((r_count != 2'd2) | w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        if (!rst && !i_flush && w_push) begin
            r_mem[r_wr_ptr] <= i_wr_dat;
        end
    end

    assign o_head_dat = (r_count != 2'd0) ? r_mem[r_rd_ptr] : '0;
    assign o_count    = r_count;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads the ROM, buffers {instr, pc} for decode; head arrives 1 cycle after fetch.
// Full buffer stalls the PC unless the head pops the same cycle; a jump flushes and reloads the PC.
module instr_fetch
    import mcpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               jmp_valid,
    input  logic [ADDR_W-1:0]  jmp_target,
    output logic [1:0]         buf_count
);

    logic [ADDR_W-1:0] r_fetch_pc;

    logic              w_push;
    logic              w_pop;
    logic [1:0]        w_count;
    fetch_entry_t      w_wr_dat;
    fetch_entry_t      w_head;

    // Valid is masked during a redirect so decode never retires a word from the old path.
    assign instr_valid = (w_count != 2'd0) & ~jmp_valid;
    assign w_pop       = instr_valid & instr_ready;
    assign w_push      = en & ~jmp_valid & ((w_count < 2'd2) | w_pop);

    assign w_wr_dat.instr = rom_data;
    assign w_wr_dat.pc    = r_fetch_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
        end else if (jmp_valid) begin
            r_fetch_pc <= jmp_target;
        end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + 1'b1;
        end
    end

    fetch_fifo2 u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_flush    (jmp_valid),
        .i_wr_dat   (w_wr_dat),
        .o_head_dat (w_head),
        .o_count    (w_count)
    );

    assign rom_addr   = r_fetch_pc;
    assign instr_data = w_head.instr;
    assign instr_pc   = w_head.pc;
    assign buf_count  = w_count;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: behavioural ROM plus a queue of expected {instr, pc} retirements.
module tb_instr_fetch;
    import mcpu_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b0;
    logic               instr_ready = 1'b0;
    logic               jmp_valid = 1'b0;
    logic [ADDR_W-1:0]  jmp_target = '0;
    logic [ADDR_W-1:0]  rom_addr;
    logic [INSTR_W-1:0] rom_data;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr_data;
    logic [ADDR_W-1:0]  instr_pc;
    logic [1:0]         buf_count;

    logic [INSTR_W-1:0] rom [256];
    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .instr_pc    (instr_pc),
        .jmp_valid   (jmp_valid),
        .jmp_target  (jmp_target),
        .buf_count   (buf_count)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    fetch_entry_t sb_q[$];
    fetch_entry_t sb_exp;
    logic         sb_on = 1'b0;

    task automatic sb_push(input logic [ADDR_W-1:0] pc, input logic [INSTR_W-1:0] ins);
        fetch_entry_t e;
        e.pc    = pc;
        e.instr = ins;
        sb_q.push_back(e);
    endtask

    // Inputs change just after posedge, so a handshake seen at negedge is the one the next edge takes.
    always @(negedge clk) begin
        if (sb_on && !rst && instr_valid && instr_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_overrun", sb_q.size(), 1);
            end else begin
                sb_exp = sb_q.pop_front();
                chk("sb_pc", instr_pc, sb_exp.pc);
                chk("sb_instr", instr_data, sb_exp.instr);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag, input int budget, output int used);
        used = 0;
        while (sb_q.size() != 0 && used < budget) begin
            cyc();
            used++;
        end
        chk(tag, sb_q.size(), 0);
        sb_on = 1'b0;
        sb_q.delete();
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        en          = 1'b0;
        instr_ready = 1'b0;
        jmp_valid   = 1'b0;
        jmp_target  = '0;
        cyc();
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int used;
        for (int i = 0; i < 256; i++) rom[i] = FILL_INSTR;
        rom[8'h00] = 6'h1F;
        rom[8'h01] = 6'h2F;
        rom[8'h02] = 6'h12;
        rom[8'h03] = 6'h28;
        rom[8'h20] = 6'h15;
        rom[8'h21] = 6'h10;
        rom[8'h22] = 6'h3A;

        // Reset state and straight-line fetch
        do_reset();
        chk("rst_valid", instr_valid, 0);
        chk("rst_count", buf_count, 0);
        chk("rst_data", instr_data, 0);
        chk("rst_pc", instr_pc, 0);
        chk("rst_rom_addr", rom_addr, 8'h00);
        rst = 1'b0;
        en = 1'b1;
        instr_ready = 1'b1;
        #1;
        chk("rel_valid", instr_valid, 0);
        sb_push(8'h00, 6'h1F);
        sb_push(8'h01, 6'h2F);
        sb_push(8'h02, 6'h12);
        sb_push(8'h03, 6'h28);
        sb_on = 1'b1;
        cyc();
        chk("lat_valid", instr_valid, 1);
        chk("lat_pc", instr_pc, 8'h00);
        wait_drain("p1_drain", 10, used);
        chk("p1_tput", used, 4);

        // Backpressure from reset, then drain at full with push+pop each cycle
        do_reset();
        rst = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (i >= 1) chk("bp_head_pc", instr_pc, 8'h00);
        end
        chk("bp_count", buf_count, 2);
        chk("bp_valid", instr_valid, 1);
        chk("bp_data", instr_data, 6'h1F);
        chk("bp_rom_addr", rom_addr, 8'h02);
        sb_push(8'h00, 6'h1F);
        sb_push(8'h01, 6'h2F);
        sb_push(8'h02, 6'h12);
        sb_on = 1'b1;
        instr_ready = 1'b1;
        used = 0;
        while (sb_q.size() != 0 && used < 8) begin
            cyc();
            used++;
            chk("full_count", buf_count, 2);
        end
        chk("bp_drain", sb_q.size(), 0);
        chk("bp_tput", used, 3);
        sb_on = 1'b0;
        sb_q.delete();

        // Redirect while full, jump held for three cycles
        jmp_valid = 1'b1;
        jmp_target = 8'h20;
        #1;
        chk("jmp_valid_mask", instr_valid, 0);
        cyc();
        chk("jmp_count", buf_count, 0);
        chk("jmp_rom_addr", rom_addr, 8'h20);
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("jmp_hold_count", buf_count, 0);
            chk("jmp_hold_valid", instr_valid, 0);
        end
        jmp_valid = 1'b0;
        chk("jmp_bubble", instr_valid, 0);
        sb_push(8'h20, 6'h15);
        sb_push(8'h21, 6'h10);
        sb_push(8'h22, 6'h3A);
        sb_push(8'h23, 6'h3F);
        sb_on = 1'b1;
        cyc();
        chk("jmp_first_valid", instr_valid, 1);
        chk("jmp_first_pc", instr_pc, 8'h20);
        wait_drain("jmp_drain", 10, used);

        // PC wraps from FF to 00
        jmp_valid = 1'b1;
        jmp_target = 8'hFF;
        cyc();
        jmp_valid = 1'b0;
        sb_push(8'hFF, 6'h3F);
        sb_push(8'h00, 6'h1F);
        sb_push(8'h01, 6'h2F);
        sb_on = 1'b1;
        wait_drain("wrap_drain", 10, used);

        // Redirect with fetch disabled stays idle until enabled
        en = 1'b0;
        jmp_valid = 1'b1;
        jmp_target = 8'h21;
        cyc();
        jmp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("idle_count", buf_count, 0);
            chk("idle_rom_addr", rom_addr, 8'h21);
        end
        sb_push(8'h21, 6'h10);
        sb_push(8'h22, 6'h3A);
        sb_on = 1'b1;
        en = 1'b1;
        wait_drain("idle_drain", 10, used);

        // Reset in the middle of a full, stalled buffer
        instr_ready = 1'b0;
        jmp_valid = 1'b1;
        jmp_target = 8'h0E;
        cyc();
        jmp_valid = 1'b0;
        cyc();
        cyc();
        chk("pre_rst_count", buf_count, 2);
        chk("pre_rst_rom_addr", rom_addr, 8'h10);
        rst = 1'b1;
        instr_ready = 1'b1;
        cyc();
        chk("mid_rst_valid", instr_valid, 0);
        chk("mid_rst_count", buf_count, 0);
        chk("mid_rst_rom_addr", rom_addr, 8'h00);
        rst = 1'b0;
        sb_push(8'h00, 6'h1F);
        sb_push(8'h01, 6'h2F);
        sb_on = 1'b1;
        wait_drain("post_rst_drain", 10, used);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
